ex_mdu: RTL and testbench
=========================

// Module: ex_mdu
// PURPOSE
//  EX-stage multiply/divide unit, upstream of MEM. Runs mult/multu/div/divu as
//  multi-cycle ops into HI/LO and executes mthi/mtlo. mfhi/mflo read hi/lo
//  directly, and EX forwards that value to MEM as the ALU-out result.
//  busy is used by the hazard unit to stall later MD instructions in D.
// PARAMETERS
//  MULT_CYCLES  5  busy cycles for mult/multu (>=1)
//  WIDTH        32 operand width; only 32 is supported
// PORTS
//  clk    in  1  rising-edge clock
//  reset  in  1  asynchronous, active-low reset
//  start  in  1  op valid this cycle (EX-stage MD instr, not stalled)
//  op     in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//  a      in  32 rs operand (forwarded)
//  b      in  32 rt operand (forwarded)
//  busy   out 1  registered; high while a mult/div is in flight
//  done   out 1  one-cycle pulse after the edge that writes HI/LO for mult/div
//  hi     out 32 HI register
//  lo     out 32 LO register
// BEHAVIOUR
//  - Reset low: state=IDLE, busy=0, done=0, hi=lo=0, counter=0. Takes effect
//    immediately, including mid-op. The op is discarded.
//  - FSM: IDLE, MUL, DIV, FIX. busy = (state != IDLE).
//  - IDLE, start, op=mult/multu: capture 64b product (signed/unsigned *).
//    Go to MUL with cnt=MULT_CYCLES-1. In MUL, cnt decrements each cycle.
//    At cnt==0 the edge writes {hi,lo}=product, sets done=1 and returns to IDLE.
//    busy is high for exactly MULT_CYCLES cycles.
//  - IDLE, start, op=div/divu: latch |a|,|b| (signed) or a,b (unsigned).
//    Latch the operand signs. Go to DIV with cnt=31.
//  - DIV: one restoring shift-subtract step per cycle, MSB first.
//    After the step at cnt==0, go to FIX.
//  - FIX: negate quotient if sign(a)^sign(b), negate remainder if sign(a)
//    (signed only). Write lo=quotient, hi=remainder, done=1, go to IDLE.
//    busy is high for 33 cycles.
//  - div truncates toward zero; remainder takes the dividend's sign.
//  - b==0: lo=0xFFFFFFFF, hi=a (both div and divu; bypasses sign fixup).
//  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  - mthi/mtlo with start in IDLE: hi (resp. lo)=a at the next edge.
//    Single cycle, busy stays 0, done stays 0.
//  - start while busy (any op): ignored. The hazard unit must stall on
//    (busy | start&op<=3). No state or HI/LO change.
//  - op 110/111 with start: ignored.
//  - hi/lo hold their old values throughout busy. They change only at the
//    completion edge or on an mthi/mtlo.
//  - done is 0 in every cycle except the one after completion.
//  - A new start may be accepted in the same cycle done=1 (state is IDLE).
// CONFIGURATION
//  MDU_FLUSH_EN defined: adds input `flush` (1b).
//    - flush=1 while busy: the next edge returns to IDLE, busy=0, done=0, and
//      hi/lo are unchanged.
//    - flush has priority over a start in the same cycle; that start is dropped.
//    - flush in IDLE with no start: no effect.
//  MDU_FLUSH_EN undefined: no `flush` port, and every accepted op always completes.
// TESTING
//  1 mult a=0xFFFFFFFF b=0x2 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE,
//    done pulses once. multu with the same operands -> hi=0x1 lo=0xFFFFFFFE.
//  2 div a=0xFFFFFFF9(-7) b=2 -> busy 33 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF.
//    divu a=7 b=2 -> lo=3 hi=1.
//  3 divu a=5 b=0 -> lo=0xFFFFFFFF hi=5.
//    div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4 idle mthi a=0x1234 -> hi=0x1234 next cycle, lo unchanged, busy=0.
//    A mult start, then mtlo on cycle 2 -> mtlo ignored, lo=product low word.
//  5 reset low on cycle 10 of a div -> busy=0, hi=lo=0, done=0 immediately.
//    After release, a new mult completes normally.
//  6 [MDU_FLUSH_EN] flush on cycle 3 of a div with hi=lo=0x55 -> busy=0 next
//    cycle, hi=lo=0x55, no done pulse.

Source files
------------

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: multi-cycle mult/multu/div/divu into HI/LO, single-cycle mthi/mtlo.
// Optional MDU_FLUSH_EN adds a `flush` input that abandons an in-flight op without touching HI/LO.
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int WIDTH       = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MDU_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t               state_r;
    logic [4:0]           cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     quot_r;
    logic [WIDTH-1:0]     dvs_r;
    logic [WIDTH-1:0]     a_raw_r;
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic                 divz_r;

    logic                 flush_s;
    logic                 is_signed_s;
    logic [2*WIDTH-1:0]   ext_a_s;
    logic [2*WIDTH-1:0]   ext_b_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic [WIDTH:0]       shift_s;
    logic                 ge_s;
    logic [WIDTH-1:0]     rem_nx_s;
    logic [WIDTH-1:0]     q_fix_s;
    logic [WIDTH-1:0]     r_fix_s;

`ifdef MDU_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // op[0] clear selects the signed variants of mult and div
    assign is_signed_s = ~op[0];
    assign ext_a_s     = {{WIDTH{a[WIDTH-1] & is_signed_s}}, a};
    assign ext_b_s     = {{WIDTH{b[WIDTH-1] & is_signed_s}}, b};
    assign prod_s      = ext_a_s * ext_b_s;
    assign abs_a_s     = (is_signed_s && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    assign abs_b_s     = (is_signed_s && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;

    // Restoring step: the next dividend bit shifts into the partial remainder
    assign shift_s  = {rem_r, quot_r[WIDTH-1]};
    assign ge_s     = (shift_s >= {1'b0, dvs_r});
    assign rem_nx_s = ge_s ? (shift_s[WIDTH-1:0] - dvs_r) : shift_s[WIDTH-1:0];
    assign q_fix_s  = neg_q_r ? (~quot_r + {{(WIDTH-1){1'b0}}, 1'b1}) : quot_r;
    assign r_fix_s  = neg_r_r ? (~rem_r + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_r;

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Control FSM, divider datapath and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            prod_r  <= '0;
            rem_r   <= '0;
            quot_r  <= '0;
            dvs_r   <= '0;
            a_raw_r <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            divz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (flush_s) begin
                state_r <= IDLE;
                cnt_r   <= 5'd0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    prod_r  <= prod_s;
                                    cnt_r   <= 5'(MULT_CYCLES - 1);
                                    state_r <= MUL;
                                    busy_r  <= 1'b1;
                                end
                                OP_DIV, OP_DIVU: begin
                                    rem_r   <= '0;
                                    quot_r  <= abs_a_s;
                                    dvs_r   <= abs_b_s;
                                    a_raw_r <= a;
                                    neg_q_r <= is_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    neg_r_r <= is_signed_s & a[WIDTH-1];
                                    divz_r  <= (b == '0);
                                    cnt_r   <= 5'd31;
                                    state_r <= DIV;
                                    busy_r  <= 1'b1;
                                end
                                OP_MTHI: hi_r <= a;
                                OP_MTLO: lo_r <= a;
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        if (cnt_r == 5'd0) begin
                            {hi_r, lo_r} <= prod_r;
                            done_r       <= 1'b1;
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - 5'd1;
                        end
                    end
                    DIV: begin
                        rem_r  <= rem_nx_s;
                        quot_r <= {quot_r[WIDTH-2:0], ge_s};
                        if (cnt_r == 5'd0) begin
                            state_r <= FIX;
                        end else begin
                            cnt_r <= cnt_r - 5'd1;
                        end
                    end
                    FIX: begin
                        // Divide-by-zero reports all-ones quotient and the raw dividend
                        if (divz_r) begin
                            lo_r <= '1;
                            hi_r <= a_raw_r;
                        end else begin
                            lo_r <= q_fix_s;
                            hi_r <= r_fix_s;
                        end
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: vector table plus scoreboard of expected {hi,lo}.
module tb_ex_mdu;

    localparam int MC = 5;
    localparam int DC = 33;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_FLUSH_EN
    logic        flush;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[11];

    ex_mdu #(.MULT_CYCLES(MC), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MDU_FLUSH_EN
        .flush (flush),
`endif
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        logic [31:0] q;
        logic [31:0] r;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Drive one start for a cycle; the edge after an accept can never be a completion
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        chk("done_low_after_issue", {63'd0, done}, 64'd0);
    endtask

    task automatic wait_done(input int exp_cyc);
        int cyc;
        logic [63:0] exp;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
        chk("busy_cycles", 64'(cyc), 64'(exp_cyc));
        chk("done_pulse", {63'd0, done}, 64'd1);
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard_empty: got completion expected none");
        end else begin
            exp = sb_q.pop_front();
            chk("hilo", {hi, lo}, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MC};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, MC};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vecs[3]  = '{3'd3, 32'h7,         32'h2,         32'h1,         32'h3,         DC};
        vecs[4]  = '{3'd3, 32'h5,         32'h0,         32'h5,         32'hFFFF_FFFF, DC};
        vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DC};
        vecs[6]  = '{3'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, DC};
        vecs[7]  = '{3'd2, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, DC};
        vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, DC};
        vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC};
        vecs[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         MC};

        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
`ifdef MDU_FLUSH_EN
        flush = 1'b0;
`endif
        tick();
        tick();
        chk("reset_state", {30'd0, busy, done, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            sb_q.push_back({vecs[i].hi, vecs[i].lo});
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].cyc);
            tick();
            chk("done_one_cycle", {63'd0, done}, 64'd0);
        end

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) rb = rb >> 27;
            sb_q.push_back(model(ro, ra, rb));
            issue(ro, ra, rb);
            wait_done(ro[1] ? DC : MC);
        end

        // mthi while idle: one cycle, lo untouched
        issue(3'd4, 32'h1234, 32'd0);
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        chk("mthi_lo_kept", {32'd0, lo}, {32'd0, sb_q.size() == 0 ? lo : 32'hX});
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        issue(3'd5, 32'hA5A5_0001, 32'd0);
        chk("mtlo_lo", {hi, lo}, {32'h1234, 32'hA5A5_0001});

        // mtlo during a mult is ignored
        sb_q.push_back(64'h0000_0000_0001_8000);
        issue(3'd1, 32'h0000_C000, 32'h2);
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        chk("held_during_busy", {hi, lo}, {32'h1234, 32'hA5A5_0001});
        wait_done(MC - 1);

        // unused opcodes are ignored
        issue(3'd6, 32'h1111_1111, 32'd0);
        issue(3'd7, 32'h2222_2222, 32'd0);
        chk("bad_op_ignored", {31'd0, busy, hi}, {31'd0, 1'b0, 32'h0});
        chk("bad_op_lo", {32'd0, lo}, 64'h0001_8000);

        // back-to-back: accept a new op in the done cycle
        sb_q.push_back(model(3'd0, 32'hFFFF_FFFD, 32'h7));
        issue(3'd0, 32'hFFFF_FFFD, 32'h7);
        wait_done(MC);
        sb_q.push_back(model(3'd3, 32'd100, 32'd7));
        issue(3'd3, 32'd100, 32'd7);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(DC - 1 + 1);

        // async reset in the middle of a div
        sb_q.push_back(64'd0);
        issue(3'd2, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b0;
        #1;
        chk("midop_reset", {30'd0, busy, done, hi}, 64'd0);
        chk("midop_reset_lo", {32'd0, lo}, 64'd0);
        void'(sb_q.pop_front());
        tick();
        reset = 1'b1;
        tick();
        sb_q.push_back(64'd42);
        issue(3'd1, 32'd6, 32'd7);
        wait_done(MC);

`ifdef MDU_FLUSH_EN
        issue(3'd4, 32'h55, 32'd0);
        issue(3'd5, 32'h55, 32'd0);
        issue(3'd2, 32'd77, 32'd5);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_state", {30'd0, busy, done, hi}, {30'd0, 1'b0, 1'b0, 32'h55});
        chk("flush_lo", {32'd0, lo}, 64'h55);
        tick();
        chk("flush_no_done", {63'd0, done}, 64'd0);
        flush = 1'b1;
        issue(3'd4, 32'h99, 32'd0);
        flush = 1'b0;
        chk("flush_drops_start", {32'd0, hi}, 64'h55);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
